// File: rtl/vga_timing_pkg.sv
// Shared constants, count type and helpers for the 640x480@60 VGA timing generator.
// Optional feature macro used by this slice: VGA_FRAME_COUNT_EN (adds a frame counter).
`timescale 1ns/1ps
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int CNT_LIMIT = 1 << CNT_W;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t wrap_inc(cnt_t val, cnt_t last);
    return (val == last) ? '0 : cnt_t'(val + 1'b1);
  endfunction

  function automatic logic in_range(cnt_t val, int lo, int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Timing bundle from the VGA timing generator to the pixel-colour stage and connector.
// With VGA_FRAME_COUNT_EN defined the bundle also carries frame_cnt.
`timescale 1ns/1ps
interface vga_timing_if;

  logic [vga_timing_pkg::CNT_W-1:0] hCount;
  logic [vga_timing_pkg::CNT_W-1:0] vCount;
  logic bright;
  logic hSync;
  logic vSync;
  logic pix_en;
  logic frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt;

  modport master (output hCount, vCount, bright, hSync, vSync, pix_en, frame_start, frame_cnt);
  modport slave  (input  hCount, vCount, bright, hSync, vSync, pix_en, frame_start, frame_cnt);
`else
  modport master (output hCount, vCount, bright, hSync, vSync, pix_en, frame_start);
  modport slave  (input  hCount, vCount, bright, hSync, vSync, pix_en, frame_start);
`endif

endinterface

// File: rtl/pix_tick_div.sv
// Board-clock divider: tick is high during the last clk of every CLK_DIV-clk pixel period,
// so the consumer can update its pixel state in the same edge that ends the period.
`timescale 1ns/1ps
module pix_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  assign tick = (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-tick divider plus h/v counters with zero-skew registered syncs.
// Define VGA_FRAME_COUNT_EN to add a 16-bit wrapping frame counter on the bundle.
`timescale 1ns/1ps
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input logic         clk,
  input logic         reset,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  if (H_TOTAL > CNT_LIMIT) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > CNT_LIMIT) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL exceeds counter range");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end

  logic w_tick;
  cnt_t w_h_next;
  cnt_t w_v_next;
  logic w_frame_hit;

  cnt_t r_h;
  cnt_t r_v;
  logic r_bright;
  logic r_hsync;
  logic r_vsync;
  logic r_pix_en;
  logic r_frame_start;

  pix_tick_div #(.CLK_DIV(CLK_DIV)) u_pix_tick_div (
    .clk   (clk),
    .reset (reset),
    .tick  (w_tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_h_next = r_h;
    w_v_next = r_v;
    if (w_tick) begin
      w_h_next = wrap_inc(r_h, H_LAST);
      if (r_h == H_LAST) begin
        w_v_next = wrap_inc(r_v, V_LAST);
      end
    end
  end

  assign w_frame_hit = w_tick && (w_h_next == '0) && (w_v_next == '0);

  // Reset parks the counters at the last back-porch position so the first tick lands on (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h           <= H_LAST;
      r_v           <= V_LAST;
      r_bright      <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_pix_en      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h           <= w_h_next;
      r_v           <= w_v_next;
      r_bright      <= in_range(w_h_next, 0, H_ACTIVE - 1) && in_range(w_v_next, 0, V_ACTIVE - 1);
      r_hsync       <= !in_range(w_h_next, H_SYNC_START, H_SYNC_START + H_SYNC - 1);
      r_vsync       <= !in_range(w_v_next, V_SYNC_START, V_SYNC_START + V_SYNC - 1);
      r_pix_en      <= w_tick;
      r_frame_start <= w_frame_hit;
    end
  end

  assign vga.hCount      = r_h;
  assign vga.vCount      = r_v;
  assign vga.bright      = r_bright;
  assign vga.hSync       = r_hsync;
  assign vga.vSync       = r_vsync;
  assign vga.pix_en      = r_pix_en;
  assign vga.frame_start = r_frame_start;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (w_frame_hit) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign vga.frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a full-size instance for line-level timing and a shrunken instance
// for whole-frame behaviour, both compared against a closed-form pixel-index model.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       bright;
    logic       hs;
    logic       vs;
    logic       pe;
    logic       fs;
  } obs_t;

  typedef struct {
    int cd;
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
  } cfg_t;

  typedef struct {
    int   n;
    obs_t exp;
  } vec_t;

  localparam int S_CD  = 3;
  localparam int S_HA  = 16;
  localparam int S_HFP = 2;
  localparam int S_HSW = 4;
  localparam int S_HBP = 3;
  localparam int S_VA  = 8;
  localparam int S_VFP = 2;
  localparam int S_VSW = 2;
  localparam int S_VBP = 3;

  logic clk   = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  always #5 clk = ~clk;

  vga_timing_if if_d();
  vga_timing_if if_s();

  vga_timing_gen dut_d (
    .clk   (clk),
    .reset (rst_d),
    .vga   (if_d)
  );

  vga_timing_gen #(
    .CLK_DIV (S_CD),
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP)
  ) dut_s (
    .clk   (clk),
    .reset (rst_s),
    .vga   (if_s)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_d    = 0;
  int n_s    = 0;

  function automatic obs_t mk(int h, int v, bit b, bit hs, bit vs, bit pe, bit fs);
    obs_t o;
    o.h = 10'(h);
    o.v = 10'(v);
    o.bright = b;
    o.hs = hs;
    o.vs = vs;
    o.pe = pe;
    o.fs = fs;
    return o;
  endfunction

  // Position after n clks out of reset: the k-th pixel tick shows pixel index k-1 of the frame.
  function automatic obs_t model(cfg_t c, int n);
    int ht, vt, f, k, p, h, v;
    obs_t o;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    f  = ht * vt;
    k  = n / c.cd;
    p  = (k + f - 1) % f;
    h  = p % ht;
    v  = p / ht;
    o.h = 10'(h);
    o.v = 10'(v);
    o.bright = (h < c.ha) && (v < c.va);
    o.hs = !((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hsw));
    o.vs = !((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vsw));
    o.pe = (n > 0) && (n % c.cd == 0);
    o.fs = o.pe && (p == 0);
    return o;
  endfunction

  function automatic obs_t get_d();
    return obs_t'({if_d.hCount, if_d.vCount, if_d.bright, if_d.hSync, if_d.vSync,
                   if_d.pix_en, if_d.frame_start});
  endfunction

  function automatic obs_t get_s();
    return obs_t'({if_s.hCount, if_s.vCount, if_s.bright, if_s.hSync, if_s.vSync,
                   if_s.pix_en, if_s.frame_start});
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got h=%0d v=%0d bright=%b hs=%b vs=%b pix_en=%b fs=%b | want h=%0d v=%0d bright=%b hs=%b vs=%b pix_en=%b fs=%b",
               name, act.h, act.v, act.bright, act.hs, act.vs, act.pe, act.fs,
               exp.h, exp.v, exp.bright, exp.hs, exp.vs, exp.pe, exp.fs);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step_d();
    @(negedge clk);
    n_d++;
  endtask

  task automatic step_s();
    @(negedge clk);
    n_s++;
  endtask

  initial begin
    cfg_t cfg_d;
    cfg_t cfg_s;
    vec_t tbl[12];
    obs_t rst_val;
    obs_t o;
    obs_t prev;
    int hs_low_clks, hs_first_h, dark_ticks, v_step_h, v_step_seen;
    int fs_seen, last_fs, lit_ticks, vs_ticks;

    cfg_d = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg_s = '{S_CD, S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP};
    rst_val = mk(799, 524, 0, 1, 1, 0, 0);

    tbl[0]  = '{0,    mk(799, 524, 0, 1, 1, 0, 0)};
    tbl[1]  = '{3,    mk(799, 524, 0, 1, 1, 0, 0)};
    tbl[2]  = '{4,    mk(0,   0,   1, 1, 1, 1, 1)};
    tbl[3]  = '{5,    mk(0,   0,   1, 1, 1, 0, 0)};
    tbl[4]  = '{8,    mk(1,   0,   1, 1, 1, 1, 0)};
    tbl[5]  = '{2560, mk(639, 0,   1, 1, 1, 1, 0)};
    tbl[6]  = '{2564, mk(640, 0,   0, 1, 1, 1, 0)};
    tbl[7]  = '{2628, mk(656, 0,   0, 0, 1, 1, 0)};
    tbl[8]  = '{3008, mk(751, 0,   0, 0, 1, 1, 0)};
    tbl[9]  = '{3012, mk(752, 0,   0, 1, 1, 1, 0)};
    tbl[10] = '{3200, mk(799, 0,   0, 1, 1, 1, 0)};
    tbl[11] = '{3204, mk(0,   1,   1, 1, 1, 1, 0)};

    // ---------------- full-size instance: first line, table driven ----------------
    repeat (3) @(negedge clk);
    check("reset_state_d", get_d(), rst_val);
    rst_d = 1'b0;
    n_d = 0;
    for (int i = 0; i < 12; i++) begin
      while (n_d < tbl[i].n) step_d();
      check($sformatf("vec%0d_n%0d", i, tbl[i].n), get_d(), tbl[i].exp);
    end

    // ---------------- async reset in the middle of hSync on line 1 ----------------
    while (n_d < 4 * (800 + 701)) step_d();
    check("pre_async_h700", get_d(), mk(700, 1, 0, 0, 1, 1, 0));
    #2 rst_d = 1'b1;
    #1 check("async_reset_now", get_d(), rst_val);
    @(negedge clk);
    check("async_reset_hold", get_d(), rst_val);
    rst_d = 1'b0;
    n_d = 0;
    for (int i = 0; i < 5; i++) begin
      while (n_d < tbl[i].n) step_d();
      check($sformatf("restart_vec%0d", i), get_d(), tbl[i].exp);
    end

    // ---------------- full line 0 sweep against the model ----------------
    hs_low_clks = 0;
    hs_first_h  = -1;
    dark_ticks  = 0;
    v_step_h    = -1;
    v_step_seen = 0;
    while (n_d < 4 * 801) begin
      step_d();
      o = get_d();
      check($sformatf("line_d_n%0d", n_d), o, model(cfg_d, n_d));
      if (!o.hs) begin
        hs_low_clks++;
        if (hs_first_h < 0) hs_first_h = int'(o.h);
      end
      if (o.pe && !o.bright && o.v == 10'd0) dark_ticks++;
      if (!v_step_seen && o.v == 10'd1) begin
        v_step_seen = 1;
        v_step_h = int'(o.h);
      end
    end
    check_int("hsync_low_clks", hs_low_clks, 384);
    check_int("hsync_first_h", hs_first_h, 656);
    check_int("line0_dark_ticks", dark_ticks, 160);
    check_int("vstep_at_h", v_step_h, 0);
    rst_d = 1'b1;

    // ---------------- shrunken instance: whole frames ----------------
    @(negedge clk);
    check("reset_state_s", get_s(), model(cfg_s, 0));
`ifdef VGA_FRAME_COUNT_EN
    check_int("frame_cnt_reset", int'(if_s.frame_cnt), 0);
`endif
    rst_s = 1'b0;
    n_s = 0;
    fs_seen = 0;
    last_fs = -1;
    lit_ticks = 0;
    vs_ticks = 0;
    prev = get_s();
    while (n_s < 3 * 1125 + 10) begin
      step_s();
      o = get_s();
      check($sformatf("frame_s_n%0d", n_s), o, model(cfg_s, n_s));
      if (o.fs) begin
        check($sformatf("wrap_from_n%0d", n_s),
              mk(int'(prev.h), int'(prev.v), 0, 0, 0, 0, 0), mk(24, 14, 0, 0, 0, 0, 0));
        if (last_fs >= 0) check_int("frame_interval", n_s - last_fs, 1125);
        last_fs = n_s;
        fs_seen++;
      end
      if (fs_seen == 1 && o.pe) begin
        if (o.bright) lit_ticks++;
        if (!o.vs) vs_ticks++;
      end
      prev = o;
    end
    check_int("frame_starts_seen", fs_seen, 4);
    check_int("bright_ticks_per_frame", lit_ticks, 128);
    check_int("vsync_ticks_per_frame", vs_ticks, 50);
`ifdef VGA_FRAME_COUNT_EN
    check_int("frame_cnt_after_frames", int'(if_s.frame_cnt), 4);
`endif

    // ---------------- random async resets at arbitrary points ----------------
    for (int r = 0; r < 8; r++) begin
      int run_len, dly, hold;
      run_len = $urandom_range(1, 1500);
      dly = $urandom_range(1, 3);
      hold = $urandom_range(1, 3);
      repeat (run_len) begin
        step_s();
        check($sformatf("rand%0d_n%0d", r, n_s), get_s(), model(cfg_s, n_s));
      end
      #(dly) rst_s = 1'b1;
      #1 check($sformatf("rand%0d_async_reset", r), get_s(), model(cfg_s, 0));
      repeat (hold) begin
        @(negedge clk);
        check($sformatf("rand%0d_reset_hold", r), get_s(), model(cfg_s, 0));
      end
`ifdef VGA_FRAME_COUNT_EN
      check_int("frame_cnt_rand_reset", int'(if_s.frame_cnt), 0);
`endif
      rst_s = 1'b0;
      n_s = 0;
    end
    repeat (400) begin
      step_s();
      check($sformatf("tail_n%0d", n_s), get_s(), model(cfg_s, n_s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
